timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
Programmable interval timer that sits on the responder side of the CPU-to-bridge I/O bus. The bridge decodes the word address and forwards the write strobe, write data and register offset to this block. The block returns register read data and drives one hardware interrupt line into the CPU's HWInt inputs. It provides one-shot and auto-reload countdown modes.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers. Valid range is 2..32.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- Addr  in  2  register word offset from the bridge: 0=CTRL, 1=PRESET, 2=COUNT, 3=PRESCALE/reserved
- WE  in  1  register write strobe, qualified by the bridge address decode
- DIN  in  32  write data
- DOUT  out  32  read data; combinational from Addr
- IRQ  out  1  interrupt request to HWInt

Behaviour:
- One clock domain: clk. Reset is synchronous and active-low (rst=0 sampled at a rising edge).
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0, DOUT=0 for every Addr.
- CTRL register fields:
  - bit0 EN
  - bits2:1 MODE: 0 = one-shot, 1 = auto-reload, 2 and 3 behave as 0
  - bit3 IM: interrupt enable
  - bits31:4 read as 0
- PRESET: read/write, low CNT_W bits. Upper bits read as 0.
- COUNT: read-only. Writes are ignored.
- Writes to CTRL or PRESET occur at the clock edge where WE=1. DOUT always reflects current register values, with zero read latency.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD. COUNT holds its value.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE (COUNT frozen). COUNT>1 -> COUNT-1. COUNT<=1 -> COUNT<=0, irq_flag<=1, go to INT.
  - INT, MODE 0: EN<=0 -> IDLE.
  - INT, MODE 1: -> LOAD, EN stays 1.
- Latency: for PRESET=N, irq_flag rises max(N,1)+2 edges after the edge that wrote EN=1. MODE 1 period is max(N,1)+2 cycles.
- IRQ = irq_flag & IM, registered output with no combinational path from inputs.
- irq_flag:
  - MODE 0: held until any CTRL write clears it.
  - MODE 1: cleared on the next LOAD, giving a 1-cycle pulse. A CTRL write also clears it.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as the INT-state EN clear: the CPU write wins.
  - A CTRL write in the same cycle the FSM would set irq_flag: the flag is set, because the set wins over the clear.
- PRESET written mid-count: takes effect only at the next LOAD.
- EN cleared mid-count: COUNT freezes. Re-enable reloads from PRESET; there is no resume.
- rst=0 mid-count: full reset as above on that edge.
- Writes to Addr=2, and to Addr=3 when the optional feature is absent, are no-ops.

Optional Feature:
- Macro: TIMER_PRESCALE_EN
- Defined:
  - Addr=3 is PRESCALE, 16-bit read/write (upper bits read 0), reset 0.
  - An internal prescale counter is cleared in LOAD and increments in CNT.
  - The CNT-state action (decrement or terminal check) fires only when the prescale counter equals PRESCALE; the counter then returns to 0.
  - Each count step takes PRESCALE+1 cycles. PRESCALE=0 gives timing identical to the undefined case.
- Undefined: Addr=3 reads 0, writes are ignored, and the CNT action fires every cycle.

Test Plan:
1. Reset: hold rst=0 for 2 edges -> DOUT=0 for Addr 0..3, IRQ=0. Write CTRL=0xF during reset -> CTRL still reads 0.
2. One-shot: PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0; IRQ rises 7 edges after the CTRL write; CTRL reads 0x8. IRQ stays 1 until CTRL=0x0 is written, then falls the next edge.
3. Auto-reload: PRESET=3, CTRL=0xB -> IRQ pulses 1 cycle every 5 cycles for at least 4 periods; CTRL stays 0xB. Write PRESET=6 mid-period -> the period after the next LOAD is 8.
4. Disable mid-count: PRESET=10, enable, write CTRL=0 when COUNT=6 -> COUNT holds 6 with no IRQ. Re-enable -> COUNT reloads 10.
5. Masking and corners: IM=0 with MODE 0 and PRESET=0 -> irq_flag set after 3 edges, IRQ stays 0. Then write CTRL=0x8 -> IRQ stays 0, because the flag is cleared by the write. Write to COUNT -> no change.
6. Prescale (TIMER_PRESCALE_EN defined): PRESCALE=2, PRESET=4, MODE 0 -> COUNT decrements every 3 cycles; IRQ rises 14 edges after enable. Not defined: Addr=3 reads 0 after writing 0x5.

Source files
------------

// File: rtl/timer_dev.sv
// timer_dev: programmable interval timer (one-shot / auto-reload) on the bridge I/O bus.
// Define TIMER_PRESCALE_EN to add the 16-bit PRESCALE register at word offset 3.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIN,
  output logic [31:0] DOUT,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag, irq_flag_next;
  logic             en, auto_reload, im_next;
  logic             ctrl_we, preset_we;
  logic             step;
  logic             load_cnt, dec_cnt, terminal, clr_en, reload_clr;
  logic             unused_din;

  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign ctrl_we     = WE && (Addr == 2'd0);
  assign preset_we   = WE && (Addr == 2'd1);
  assign unused_din  = ^DIN;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic        prescale_we;

  assign prescale_we = WE && (Addr == 2'd3);
  // A count step only fires once the prescale counter reaches PRESCALE.
  assign step = (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (prescale_we) prescale <= DIN[15:0];
      if (state == LOAD)           pcnt <= '0;
      else if (state == CNT && en) pcnt <= step ? 16'd0 : pcnt + 16'd1;
    end
  end
`else
  assign step = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = LOAD;
      LOAD: state_next = CNT;
      CNT: begin
        if (!en)                              state_next = IDLE;
        else if (step && count <= CNT_W'(1))  state_next = INT;
      end
      INT:  state_next = auto_reload ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    terminal   = 1'b0;
    clr_en     = 1'b0;
    reload_clr = 1'b0;
    case (state)
      LOAD: load_cnt = 1'b1;
      CNT: begin
        if (en && step) begin
          if (count > CNT_W'(1)) dec_cnt  = 1'b1;
          else                   terminal = 1'b1;
        end
      end
      INT: begin
        if (auto_reload) reload_clr = 1'b1;
        else             clr_en     = 1'b1;
      end
      default: ;
    endcase
  end

  // Auto-reload drops the flag as the FSM heads back into LOAD, giving a 1-cycle pulse.
  // The terminal-count set is applied last so it wins over a same-edge CTRL write.
  always_comb begin
    irq_flag_next = irq_flag;
    if (ctrl_we || reload_clr) irq_flag_next = 1'b0;
    if (terminal)              irq_flag_next = 1'b1;
    im_next = ctrl_we ? DIN[3] : ctrl[3];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      // A CPU CTRL write overrides the one-shot EN clear on the same edge.
      if (ctrl_we)     ctrl    <= DIN[3:0];
      else if (clr_en) ctrl[0] <= 1'b0;

      if (preset_we) preset <= DIN[CNT_W-1:0];

      if (load_cnt)      count <= preset;
      else if (dec_cnt)  count <= count - CNT_W'(1);
      else if (terminal) count <= '0;

      irq_flag <= irq_flag_next;
      // Registered from next-state values so IRQ rises on the same edge as the flag.
      IRQ      <= irq_flag_next & im_next;
    end
  end

  always_comb begin
    DOUT = '0;
    case (Addr)
      2'd0: DOUT[3:0]       = ctrl;
      2'd1: DOUT[CNT_W-1:0] = preset;
      2'd2: DOUT[CNT_W-1:0] = count;
`ifdef TIMER_PRESCALE_EN
      2'd3: DOUT[15:0]      = prescale;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: self-checking bench for timer_dev with directed and randomized scenarios.
// Expected timing is computed from the register/latency rules, not from the FSM encoding.
`timescale 1ns/1ps
module tb_timer_dev;

  localparam int CNT_W = 16;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        WE   = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic [31:0] DIN  = 32'd0;
  logic [31:0] DOUT;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  timer_dev #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WE(WE), .DIN(DIN), .DOUT(DOUT), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: flag rises this many edges after the enabling write edge.
  function automatic int irq_latency(input int n, input int ps);
    return ((n < 1) ? 1 : n) * (ps + 1) + 2;
  endfunction

  // Reference: COUNT value e edges after the enabling write edge (valid for e >= 2).
  function automatic int exp_count(input int n, input int ps, input int e);
    int v;
    v = n - (e - 2) / (ps + 1);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    DIN  = d;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DOUT;
  endtask

  task automatic wait_rise(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (IRQ === 1'b1) begin
        at = edge_n;
        break;
      end
    end
  endtask

  task automatic settle();
    wr(2'd0, 32'd0);
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    Addr = 2'd0; DIN = 32'hF; WE = 1'b1;
    tick(); tick();
    WE = 1'b0;
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 0", a, d); end
    end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic        ei;
    int          t0, lat;
    lat = irq_latency(5, 0);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    t0 = edge_n;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      rd(2'd2, d);
      n_checks++;
      if (d !== 32'(exp_count(5, 0, edge_n - t0))) begin
        n_fail++; $display("FAIL oneshot_count e%0d: got %0d expected %0d", edge_n - t0, d, exp_count(5, 0, edge_n - t0));
      end
      ei = (edge_n - t0 >= lat);
      n_checks++;
      if (IRQ !== ei) begin n_fail++; $display("FAIL oneshot_irq e%0d: got %b expected %b", edge_n - t0, IRQ, ei); end
    end
    tick();
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl: got %h expected 8", d); end
    tick(); tick(); tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_held: got %b expected 1", IRQ); end
    wr(2'd0, 32'h0);
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ); end
    tick(); tick();
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int          t0, at, prev;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    t0 = edge_n;
    wait_rise(20, at);
    n_checks++;
    if (at - t0 !== irq_latency(3, 0)) begin n_fail++; $display("FAIL auto_first: got %0d expected %0d", at - t0, irq_latency(3, 0)); end
    tick();
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL auto_pulse_width: got %b expected 0", IRQ); end
    prev = at;
    for (int k = 0; k < 4; k++) begin
      wait_rise(20, at);
      n_checks++;
      if (at - prev !== irq_latency(3, 0)) begin n_fail++; $display("FAIL auto_period[%0d]: got %0d expected %0d", k, at - prev, irq_latency(3, 0)); end
      prev = at;
      rd(2'd0, d);
      n_checks++;
      if (d !== 32'hB) begin n_fail++; $display("FAIL auto_ctrl[%0d]: got %h expected b", k, d); end
    end
    // PRESET lands after the reload that followed the last pulse.
    tick(); tick();
    wr(2'd1, 32'd6);
    wait_rise(20, at);
    n_checks++;
    if (at - prev !== irq_latency(3, 0)) begin n_fail++; $display("FAIL auto_old_period: got %0d expected %0d", at - prev, irq_latency(3, 0)); end
    prev = at;
    wait_rise(20, at);
    n_checks++;
    if (at - prev !== irq_latency(6, 0)) begin n_fail++; $display("FAIL auto_new_period: got %0d expected %0d", at - prev, irq_latency(6, 0)); end
    settle();
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bit          found;
    bit          any_irq;
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      rd(2'd2, d);
      if (d == 32'd7) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL disable_reach7: got %0d expected 7", d); end
    // The disabling write lands on the edge where COUNT steps 7 -> 6.
    wr(2'd0, 32'h8);
    any_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IRQ !== 1'b0) any_irq = 1'b1;
    end
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'd6) begin n_fail++; $display("FAIL disable_freeze: got %0d expected 6", d); end
    n_checks++;
    if (any_irq) begin n_fail++; $display("FAIL disable_irq: got 1 expected 0"); end
    wr(2'd2, 32'h1234);
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'd6) begin n_fail++; $display("FAIL count_readonly: got %h expected 6", d); end
    wr(2'd0, 32'h9);
    tick(); tick();
    rd(2'd2, d);
    n_checks++;
    if (d !== 32'd10) begin n_fail++; $display("FAIL disable_reload: got %0d expected 10", d); end
    settle();
  endtask

  task automatic test_mask();
    logic [31:0] d;
    bit          any_irq;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    any_irq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (IRQ !== 1'b0) any_irq = 1'b1;
    end
    n_checks++;
    if (any_irq) begin n_fail++; $display("FAIL mask_irq_im0: got 1 expected 0"); end
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mask_ctrl_done: got %h expected 0", d); end
    wr(2'd0, 32'h8);
    any_irq = (IRQ !== 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (IRQ !== 1'b0) any_irq = 1'b1;
    end
    n_checks++;
    if (any_irq) begin n_fail++; $display("FAIL mask_irq_after_im: got 1 expected 0"); end
    settle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    int          at, tw;
    // CTRL write on the same edge as the terminal set: the set wins.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(); tick();
    wr(2'd0, 32'h8);
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL simul_set_wins: got %b expected 1", IRQ); end
    settle();
    // CTRL write on the same edge as the one-shot EN clear: the CPU value wins.
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    n_checks++;
    if (IRQ !== 1'b1) begin n_fail++; $display("FAIL simul_pre_irq: got %b expected 1", IRQ); end
    wr(2'd0, 32'h9);
    tw = edge_n;
    rd(2'd0, d);
    n_checks++;
    if (d !== 32'h9) begin n_fail++; $display("FAIL simul_cpu_wins: got %h expected 9", d); end
    n_checks++;
    if (IRQ !== 1'b0) begin n_fail++; $display("FAIL simul_flag_cleared: got %b expected 0", IRQ); end
    wait_rise(10, at);
    n_checks++;
    if (at - tw !== irq_latency(1, 0)) begin n_fail++; $display("FAIL simul_rearm: got %0d expected %0d", at - tw, irq_latency(1, 0)); end
    settle();
  endtask

  task automatic test_random();
    logic [31:0] d, pv, mask, cw, exp_ctrl;
    logic [1:0]  mode;
    logic        im, auto_m, ei;
    int          n, t0, lat, at, at2;
    bit          any_irq;
    mask = '1;
    mask = mask >> (32 - CNT_W);
    for (int it = 0; it < 8; it++) begin
      n    = int'($urandom_range(0, 9));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      pv   = $urandom;
      wr(2'd1, pv);
      rd(2'd1, d);
      n_checks++;
      if (d !== (pv & mask)) begin n_fail++; $display("FAIL rand_preset_rb[%0d]: got %h expected %h", it, d, pv & mask); end
      wr(2'd1, 32'(n));
      cw = {28'd0, im, mode, 1'b1};
      auto_m = (mode == 2'd1);
      lat = irq_latency(n, 0);
      wr(2'd0, cw);
      t0 = edge_n;
      if (im) begin
        wait_rise(lat + 4, at);
        n_checks++;
        if (at - t0 !== lat) begin n_fail++; $display("FAIL rand_latency[%0d] n=%0d mode=%0d: got %0d expected %0d", it, n, mode, at - t0, lat); end
        if (auto_m) begin
          wait_rise(lat + 4, at2);
          n_checks++;
          if (at2 - at !== lat) begin n_fail++; $display("FAIL rand_period[%0d] n=%0d: got %0d expected %0d", it, n, at2 - at, lat); end
        end
      end else begin
        any_irq = 1'b0;
        for (int i = 0; i < lat + 3; i++) begin
          tick();
          if (IRQ !== 1'b0) any_irq = 1'b1;
        end
        n_checks++;
        if (any_irq) begin n_fail++; $display("FAIL rand_masked[%0d]: got 1 expected 0", it); end
      end
      tick();
      ei = im & ~auto_m;
      n_checks++;
      if (IRQ !== ei) begin n_fail++; $display("FAIL rand_irq_after[%0d] mode=%0d: got %b expected %b", it, mode, IRQ, ei); end
      exp_ctrl = auto_m ? cw : (cw & ~32'd1);
      rd(2'd0, d);
      n_checks++;
      if (d !== exp_ctrl) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %h expected %h", it, d, exp_ctrl); end
      settle();
      n_checks++;
      if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rand_irq_cleared[%0d]: got %b expected 0", it, IRQ); end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
`ifdef TIMER_PRESCALE_EN
    logic        ei;
    int          t0, lat;
    wr(2'd3, 32'hFFFF_0002);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL prescale_rb: got %h expected 2", d); end
    lat = irq_latency(4, 2);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    t0 = edge_n;
    tick();
    for (int k = 0; k < lat - 1; k++) begin
      tick();
      rd(2'd2, d);
      n_checks++;
      if (d !== 32'(exp_count(4, 2, edge_n - t0))) begin
        n_fail++; $display("FAIL prescale_count e%0d: got %0d expected %0d", edge_n - t0, d, exp_count(4, 2, edge_n - t0));
      end
      ei = (edge_n - t0 >= lat);
      n_checks++;
      if (IRQ !== ei) begin n_fail++; $display("FAIL prescale_irq e%0d: got %b expected %b", edge_n - t0, IRQ, ei); end
    end
    settle();
    wr(2'd3, 32'd0);
`else
    wr(2'd3, 32'h5);
    rd(2'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL addr3_reserved: got %h expected 0", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable();
    test_mask();
    test_simultaneous();
    test_random();
    test_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
